// File: rtl/fp32_mult_sched_if.sv
// Handshake and datapath bundle between lane operand buffers, the shared
// fp32 multiplier and the result consumer. The scheduler takes the slave side.
interface fp32_mult_sched_if #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [31:0]     mul_y;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic [IDW-1:0]  res_id;

  modport slave (
    input  req_valid, req_a, req_b, mul_y, res_ready,
    output req_ready, mul_a, mul_b, res_valid, res_data, res_id
  );

  modport master (
    output req_valid, req_a, req_b, mul_y, res_ready,
    input  req_ready, mul_a, mul_b, res_valid, res_data, res_id
  );
endinterface

// File: rtl/fp32_mult_sched.sv
// Round-robin issue of N lanes onto one pipelined fp32 multiplier. A credit
// counter covers in-flight ops plus FIFO occupancy, so the result FIFO can
// never be written while full and the multiplier needs no stall.
module fp32_mult_sched #(
  parameter int N     = 4,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  fp32_mult_sched_if.slave bus
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]  used_q, used_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] grant;
  logic           any_valid;
  logic           can_issue;
  logic           accept;
  logic           pop;
  logic           wr;

  logic [LAT-1:0] tag_v_q;
  logic [IDW-1:0] tag_id_q [LAT];

  logic [31:0]    mem_data_q [DEPTH];
  logic [IDW-1:0] mem_id_q   [DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;

  // Credits come from the registered count only, so a pop frees a slot for
  // the following cycle rather than the same one.
  assign can_issue = (used_q < CW'(DEPTH));
  assign accept    = rstn & any_valid & can_issue;

  // Scan lanes starting at ptr, wrapping mod N; the first valid lane wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_valid = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!any_valid && bus.req_valid[idx]) begin
        any_valid = 1'b1;
        grant     = IDW'(idx);
      end
    end
  end

  // Ready is one-hot on the granted lane, operands steered only on accept.
  always_comb begin
    bus.req_ready = '0;
    bus.mul_a     = 32'h0;
    bus.mul_b     = 32'h0;
    if (accept) begin
      bus.req_ready[grant] = 1'b1;
      bus.mul_a            = bus.req_a[32*grant +: 32];
      bus.mul_b            = bus.req_b[32*grant +: 32];
    end
  end

  // Next credit count and arbiter pointer.
  always_comb begin
    used_d = used_q;
    ptr_d  = ptr_q;
    case ({accept, pop})
      2'b10:   used_d = used_q + CW'(1);
      2'b01:   used_d = used_q - CW'(1);
      default: used_d = used_q;
    endcase
    if (accept) begin
      ptr_d = IDW'((int'(grant) + 1) % N);
    end
  end

  // Credit counter, pointer and tag valid pipeline.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      used_q  <= '0;
      ptr_q   <= '0;
      tag_v_q <= '0;
    end else begin
      used_q     <= used_d;
      ptr_q      <= ptr_d;
      tag_v_q[0] <= accept;
      for (int k = 1; k < LAT; k++) begin
        tag_v_q[k] <= tag_v_q[k-1];
      end
    end
  end

  // Tag ids travel with the valids; a stale id under an invalid tag is harmless.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= grant;
    for (int k = 1; k < LAT; k++) begin
      tag_id_q[k] <= tag_id_q[k-1];
    end
  end

  // mul_y lines up with the last tag stage; bubbles are never written.
  assign wr            = tag_v_q[LAT-1];
  assign bus.res_valid = rstn & (count_q != '0);
  assign pop           = bus.res_valid & bus.res_ready;
  assign bus.res_data  = bus.res_valid ? mem_data_q[rd_ptr_q] : 32'h0;
  assign bus.res_id    = bus.res_valid ? mem_id_q[rd_ptr_q] : '0;

  // FIFO pointers and occupancy; pointers wrap mod DEPTH.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr) begin
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({wr, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents past reset are unreachable because count is zero.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem_data_q[wr_ptr_q] <= bus.mul_y;
      mem_id_q[wr_ptr_q]   <= tag_id_q[LAT-1];
    end
  end
endmodule

// File: tb/tb_fp32_mult_sched.sv
// Directed bench for fp32_mult_sched with a round-robin/credit reference model
// and an in-order scoreboard of expected {data, id, arrival cycle}.
module tb_fp32_mult_sched;
  localparam int N     = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int IDW   = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fp32_mult_sched_if #(.N(N)) bus ();

  fp32_mult_sched #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Multiplier stand-in: LAT registers of mul_a ^ mul_b, never reset.
  logic [31:0] pipe [LAT];
  logic        junk_en = 1'b0;
  logic [31:0] junk_q  = 32'h0;
  always @(posedge clk) begin
    pipe[0] <= bus.mul_a ^ bus.mul_b;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    junk_q <= (junk_q * 32'd1664525) + 32'd1013904223;
  end
  assign bus.mul_y = junk_en ? junk_q : pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0]    data;
    logic [IDW-1:0] id;
    int unsigned    due;
  } exp_t;
  exp_t q[$];

  int unsigned cyc = 0;
  int unsigned cnt [N];
  int          m_ptr  = 0;
  int          m_used = 0;
  int          n_acc  = 0;
  logic        rr_phase = 1'b0;
  logic        auto_ops = 1'b1;

  int          m_g;
  logic        m_found;
  logic [N-1:0] m_rdy;
  logic        m_rv;
  logic        m_pop;
  logic [31:0] m_a, m_b;
  exp_t        m_e;

  function automatic logic [31:0] op_a(input int i, input int unsigned c);
    return 32'h3F80_0000 ^ (32'(i) << 24) ^ (c * 32'h0001_3579);
  endfunction
  function automatic logic [31:0] op_b(input int i, input int unsigned c);
    return 32'h4120_0000 ^ (32'(i) << 4) ^ (c * 32'h0024_68AC);
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_res_valid", 32'(bus.res_valid), 32'h0);
      check("rst_mul_a", bus.mul_a, 32'h0);
      q.delete();
      m_ptr  = 0;
      m_used = 0;
    end else begin
      m_found = 1'b0;
      m_g     = 0;
      for (int k = 0; k < N; k++) begin
        if (!m_found && bus.req_valid[(m_ptr + k) % N] === 1'b1) begin
          m_found = 1'b1;
          m_g     = (m_ptr + k) % N;
        end
      end
      m_rdy = '0;
      if (m_found && m_used < DEPTH) m_rdy[m_g] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(m_rdy));
      m_a = (m_rdy != 0) ? bus.req_a[32*m_g +: 32] : 32'h0;
      m_b = (m_rdy != 0) ? bus.req_b[32*m_g +: 32] : 32'h0;
      check("mul_a", bus.mul_a, m_a);
      check("mul_b", bus.mul_b, m_b);
      m_rv = (q.size() > 0) && (q[0].due <= cyc);
      check("res_valid", 32'(bus.res_valid), 32'(m_rv));
      m_pop = m_rv && (bus.res_ready === 1'b1);
      if (m_pop) begin
        m_e = q.pop_front();
        check("res_data", bus.res_data, m_e.data);
        check("res_id", 32'(bus.res_id), 32'(m_e.id));
        m_used--;
      end
      if (m_rdy != 0) begin
        m_e.data = m_a ^ m_b;
        m_e.id   = IDW'(m_g);
        m_e.due  = cyc + LAT + 1;
        q.push_back(m_e);
        cnt[m_g]++;
        n_acc++;
        m_used++;
        m_ptr = (m_g + 1) % N;
      end
      check("credit_no_overflow", 32'(m_used <= DEPTH), 32'h1);
      if (rr_phase) check("rr_used_bound", 32'(m_used <= LAT + 1), 32'h1);
    end
  end

  // Advance one cycle and present fresh operands for lanes that were accepted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ops) begin
      for (int i = 0; i < N; i++) begin
        bus.req_a[32*i +: 32] = op_a(i, cnt[i]);
        bus.req_b[32*i +: 32] = op_b(i, cnt[i]);
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    while ((q.size() != 0 || m_used != 0) && k < 100) begin
      tick();
      k++;
    end
    check("drain_in_time", 32'(k < 100), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int k;
    int a0;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_res_data", bus.res_data, 32'h0);
    check("rst_res_id", 32'(bus.res_id), 32'h0);
    tick();
    rstn = 1'b1;

    // Single op, lane 0
    auto_ops = 1'b0;
    tick();
    bus.req_valid        = 4'b0001;
    bus.req_a[31:0]      = 32'h4000_0000;
    bus.req_b[31:0]      = 32'h4040_0000;
    @(negedge clk);
    check("single_ready", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = '0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.res_valid !== 1'b1 && k < 20);
    check("single_latency", 32'(k), 32'(LAT + 1));
    check("single_data", bus.res_data, 32'h0040_0000);
    check("single_id", 32'(bus.res_id), 32'h0);
    tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("single_popped", 32'(bus.res_valid), 32'h0);

    // Round robin, continuous
    auto_ops = 1'b1;
    tick();
    bus.req_valid = 4'b1111;
    bus.res_ready = 1'b1;
    rr_phase      = 1'b1;
    a0 = n_acc;
    repeat (40) tick();
    rr_phase = 1'b0;
    check("rr_accepts", 32'(n_acc - a0), 32'd40);
    drain();

    // Backpressure fills all credits
    tick();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b1111;
    a0 = n_acc;
    repeat (20) tick();
    @(negedge clk);
    check("bp_accepts", 32'(n_acc - a0), 32'd8);
    check("bp_ready_zero", 32'(bus.req_ready), 32'h0);
    check("bp_res_valid", 32'(bus.res_valid), 32'h1);

    // One pop frees exactly one credit; second pop collides with that write
    tick();
    bus.res_ready = 1'b1;
    a0 = n_acc;
    tick();
    bus.res_ready = 1'b0;
    @(negedge clk);
    check("pulse_next_accept", 32'(bus.req_ready != 0), 32'h1);
    tick();
    tick();
    tick();
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("boundary_res_valid", 32'(bus.res_valid), 32'h1);
    check("pulse_single_accept", 32'(n_acc - a0), 32'd1);
    tick();
    bus.res_ready = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("boundary_accepts", 32'(n_acc - a0), 32'd2);
    check("boundary_full_ready", 32'(bus.req_ready), 32'h0);
    tick();
    bus.res_ready = 1'b1;
    repeat (12) tick();
    drain();

    // Pointer follows the last grant
    tick();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    check("ptr_lane2", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b1010;
    @(negedge clk);
    check("ptr_lane3_first", 32'(bus.req_ready), 32'h8);
    tick();
    @(negedge clk);
    check("ptr_lane1_next", 32'(bus.req_ready), 32'h2);
    tick();
    drain();

    // Reset with ops in flight
    tick();
    bus.res_ready = 1'b0;
    bus.req_valid = 4'b0111;
    repeat (3) tick();
    rstn          = 1'b0;
    junk_en       = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("midrst_res_valid", 32'(bus.res_valid), 32'h0);
    check("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    rstn          = 1'b1;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("midrst_quiet", 32'(bus.res_valid), 32'h0);
      tick();
    end
    junk_en = 1'b0;
    tick();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    check("midrst_ptr_zero", 32'(bus.req_ready), 32'h1);
    tick();
    drain();

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
